uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter producing 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). It sits between on-chip logic and the board's serial TX pin, as the transmit-side counterpart of the UART receiver. Bytes enter through a valid/ready handshake into a one-entry holding buffer, so a queued byte follows the current frame with no idle gap. Baud timing comes from an internal cycle counter.

Parameters:
BAUD_COUNT_WIDTH, 9, width of the baud cycle counter; must satisfy 2^BAUD_COUNT_WIDTH > FULL_BAUD_COUNT_TOP.
FULL_BAUD_COUNT_TOP, 434, clock cycles per bit (50 MHz / 115200).
BIT_COUNT_WIDTH, 4, width of the frame bit counter.
BIT_COUNT_TOP, 10, bits per frame (start + 8 data + stop).

Ports:
clk  input  1  system clock; all logic on rising edge.
rstn  input  1  reset, asynchronous, active-low.
tx_valid  input  1  tx_data holds a byte to send.
tx_data  input  8  byte to transmit.
tx_ready  output  1  holding buffer empty; byte accepted when tx_valid && tx_ready at a clock edge.
serial_dat_out  output  1  serial line, registered, idles high.
busy  output  1  high while a frame is on the line (state != IDLE).
packet_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (asynchronous, rstn=0): state=IDLE, serial_dat_out=1, busy=0, packet_done=0, holding buffer empty (tx_ready=1), baud and bit counters=0, shift register=0. Reset mid-frame aborts the frame and drives the line high immediately; a buffered byte is discarded.
- Holding buffer: tx_ready = ~buf_full. Accept sets buf_full and latches tx_data. While buf_full=1, tx_valid is ignored and tx_data is not sampled.
- States: IDLE, START, DATA, STOP.
- IDLE: serial_dat_out=1. If buf_full: on the next edge, load the shift register from the buffer, clear buf_full, zero both counters, and enter START. A byte accepted at edge E0 drives the line low from edge E1, so latency is 1 cycle.
- Bit timing: the baud counter runs 0..FULL_BAUD_COUNT_TOP-1. The bit boundary is the edge where the counter equals FULL_BAUD_COUNT_TOP-1; the counter then wraps to 0. Every bit is exactly FULL_BAUD_COUNT_TOP cycles.
- START: serial_dat_out=0 for one bit, then DATA.
- DATA: serial_dat_out=shift_reg[0]. At each bit boundary, shift right and increment the bit counter. After the 8th data bit, enter STOP.
- STOP: serial_dat_out=1 for one bit. packet_done=1 during the cycle where the baud counter equals FULL_BAUD_COUNT_TOP-1.
  - If buf_full at that boundary: load the buffer, clear buf_full, and go directly to START (back-to-back, no idle cycle).
  - Else: go to IDLE.
- Bit counter tracks frame position 0..BIT_COUNT_TOP-1. It resets to 0 on frame start.
- tx_ready goes high again on the edge that moves the buffer into the shift register. A new byte may be accepted on the very next edge, while the prior frame is still transmitting.
- Full frame: BIT_COUNT_TOP × FULL_BAUD_COUNT_TOP cycles from the first low cycle to the end of the stop bit.
- Changes to tx_data after acceptance have no effect on the frame.
- No output glitches: serial_dat_out, busy and packet_done are all registered.

Test Plan:
- FULL_BAUD_COUNT_TOP=4; send 0xA5 from idle -> line low 1 cycle after accept; per-4-cycle bits 0,1,0,1,0,0,1,0,1,1; packet_done high exactly on cycle 40 of the frame; busy 0 afterward; line stays 1.
- Back-to-back 0x00 then 0xFF (second byte offered right after tx_ready rises) -> 80 contiguous cycles; the first frame's stop bit is followed immediately by the second start bit; two packet_done pulses 40 cycles apart.
- With a frame running, accept 0x3C (buffer full), then hold tx_valid=1 with tx_data=0x77 -> tx_ready stays 0 and 0x77 is not sent until tx_ready returns; 0x3C is transmitted next with no gap.
- Assert rstn=0 asynchronously during data bit 4 of 0x81 with a byte buffered -> line high immediately, tx_ready=1, busy=0; after release the line stays idle and no frame is emitted.
- Default parameters, send 0x55 -> each bit lasts 434 cycles and the frame lasts 4340 cycles; a bench sampling at mid-bit recovers 0x55.
- tx_valid asserted in the same cycle that rstn deasserts -> byte accepted on the first active edge; start bit begins 1 cycle later.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer in front of the shift register.
// A byte waiting in the buffer at the end of a stop bit starts the next frame without an idle gap.
module uart_tx #(
  parameter int unsigned BAUD_COUNT_WIDTH    = 9,
  parameter int unsigned FULL_BAUD_COUNT_TOP = 434,
  parameter int unsigned BIT_COUNT_WIDTH     = 4,
  parameter int unsigned BIT_COUNT_TOP       = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       serial_dat_out,
  output logic       busy,
  output logic       packet_done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [BAUD_COUNT_WIDTH-1:0] BAUD_LAST     = BAUD_COUNT_WIDTH'(FULL_BAUD_COUNT_TOP - 1);
  localparam logic [BIT_COUNT_WIDTH-1:0]  LAST_DATA_POS = BIT_COUNT_WIDTH'(BIT_COUNT_TOP - 2);

  state_e                      state_q, state_d;
  logic [BAUD_COUNT_WIDTH-1:0] baud_q, baud_d;
  logic [BIT_COUNT_WIDTH-1:0]  bit_q, bit_d;
  logic [7:0]                  shift_q, shift_d;
  logic [7:0]                  buf_q, buf_d;
  logic                        buf_full_q, buf_full_d;
  logic                        tx_q, tx_d;
  logic                        busy_q, busy_d;
  logic                        pkt_q, pkt_d;
  logic                        bit_end;
  logic                        load;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    load       = 1'b0;
    bit_end    = (baud_q == BAUD_LAST);

    if (tx_valid && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_d      = tx_data;
    end

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (buf_full_q) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = bit_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_DATA_POS) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (buf_full_q) load = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading cannot coincide with an accept: a load needs buf_full_q, which blocks accepts.
    if (load) begin
      state_d    = START;
      shift_d    = buf_q;
      buf_full_d = 1'b0;
      baud_d     = '0;
      bit_d      = '0;
    end

    // Outputs are derived from the next state so the registered pins line up with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    pkt_d  = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      pkt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      pkt_q      <= pkt_d;
    end
  end

  assign tx_ready       = ~buf_full_q;
  assign serial_dat_out = tx_q;
  assign busy           = busy_q;
  assign packet_done    = pkt_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a short-baud instance for frame-level checks and a
// default-parameter instance for real bit timing.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       v_s, rdy_s, line_s, busy_s, pkt_s;
  logic [7:0] d_s;
  logic       v_d, rdy_d, line_d, busy_d, pkt_d;
  logic [7:0] d_d;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(
    .BAUD_COUNT_WIDTH   (3),
    .FULL_BAUD_COUNT_TOP(4),
    .BIT_COUNT_WIDTH    (4),
    .BIT_COUNT_TOP      (10)
  ) dut_s (
    .clk           (clk),
    .rstn          (rstn),
    .tx_valid      (v_s),
    .tx_data       (d_s),
    .tx_ready      (rdy_s),
    .serial_dat_out(line_s),
    .busy          (busy_s),
    .packet_done   (pkt_s)
  );

  uart_tx dut_d (
    .clk           (clk),
    .rstn          (rstn),
    .tx_valid      (v_d),
    .tx_data       (d_d),
    .tx_ready      (rdy_d),
    .serial_dat_out(line_d),
    .busy          (busy_d),
    .packet_done   (pkt_d)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line bits in send order, bit 0 first
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick_s(input logic exp_line, input logic exp_pkt, input string nm);
    @(negedge clk);
    chk({nm, " line"}, 32'(line_s), 32'(exp_line));
    chk({nm, " pkt"}, 32'(pkt_s), 32'(exp_pkt));
    chk({nm, " busy"}, 32'(busy_s), 32'd1);
  endtask

  // Returns at the negedge after the accepting edge; tx_data is scrambled afterwards.
  task automatic send_s(input logic [7:0] b);
    @(negedge clk);
    chk("ready before send", 32'(rdy_s), 32'd1);
    v_s = 1'b1;
    d_s = b;
    @(negedge clk);
    v_s = 1'b0;
    d_s = ~b;
    chk("ready after accept", 32'(rdy_s), 32'd0);
    chk("line high in accept cycle", 32'(line_s), 32'd1);
  endtask

  task automatic idle_after_s(input string nm);
    @(negedge clk);
    chk({nm, " idle busy"}, 32'(busy_s), 32'd0);
    chk({nm, " idle line"}, 32'(line_s), 32'd1);
    chk({nm, " idle pkt"}, 32'(pkt_s), 32'd0);
    chk({nm, " idle ready"}, 32'(rdy_s), 32'd1);
  endtask

  task automatic wait_idle_s();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy_s && rdy_s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("wait idle timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [9:0] fr;
    logic [9:0] rx;

    vecs[0] = '{data: 8'hA5, frame: 10'h34A};
    vecs[1] = '{data: 8'h00, frame: 10'h200};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[3] = '{data: 8'h3C, frame: 10'h278};
    vecs[4] = '{data: 8'h55, frame: 10'h2AA};

    rstn = 1'b0;
    v_s  = 1'b0;
    d_s  = '0;
    v_d  = 1'b0;
    d_d  = '0;
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(rdy_s), 32'd1);
    chk("reset line", 32'(line_s), 32'd1);
    chk("reset busy", 32'(busy_s), 32'd0);
    chk("reset pkt", 32'(pkt_s), 32'd0);
    chk("reset ready dflt", 32'(rdy_d), 32'd1);
    chk("reset line dflt", 32'(line_d), 32'd1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post reset line", 32'(line_s), 32'd1);

    // Single frames from idle, one table entry at a time
    for (int v = 0; v < 5; v++) begin
      wait_idle_s();
      send_s(vecs[v].data);
      fr = vecs[v].frame;
      for (int k = 1; k <= 40; k++) begin
        tick_s(fr[(k-1)/4], k == 40, $sformatf("vec%0d k%0d", v, k));
      end
      idle_after_s($sformatf("vec%0d", v));
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d line stays high", v), 32'(line_s), 32'd1);
    end

    // Back-to-back 0x00 then 0xFF: 80 contiguous cycles
    wait_idle_s();
    send_s(8'h00);
    fr = 10'h200;
    for (int k = 1; k <= 40; k++) begin
      tick_s(fr[(k-1)/4], k == 40, $sformatf("b2b0 k%0d", k));
      if (k == 1) begin
        chk("b2b ready after load", 32'(rdy_s), 32'd1);
        v_s = 1'b1;
        d_s = 8'hFF;
      end
      if (k == 2) begin
        chk("b2b second accepted", 32'(rdy_s), 32'd0);
        v_s = 1'b0;
        d_s = 8'h00;
      end
    end
    fr = 10'h3FE;
    for (int k = 1; k <= 40; k++) begin
      tick_s(fr[(k-1)/4], k == 40, $sformatf("b2b1 k%0d", k));
    end
    idle_after_s("b2b");

    // Buffer full: 0x3C queued, 0x77 held on the bus must wait for tx_ready
    wait_idle_s();
    send_s(8'hA5);
    fr = 10'h34A;
    for (int k = 1; k <= 40; k++) begin
      tick_s(fr[(k-1)/4], k == 40, $sformatf("full0 k%0d", k));
      if (k == 1) begin
        v_s = 1'b1;
        d_s = 8'h3C;
      end
      if (k == 2) d_s = 8'h77;
      if (k >= 2) chk($sformatf("full ready low k%0d", k), 32'(rdy_s), 32'd0);
    end
    fr = 10'h278;
    for (int k = 1; k <= 40; k++) begin
      tick_s(fr[(k-1)/4], k == 40, $sformatf("full1 k%0d", k));
      if (k == 1) chk("full ready back", 32'(rdy_s), 32'd1);
      if (k == 2) begin
        chk("full 0x77 accepted", 32'(rdy_s), 32'd0);
        v_s = 1'b0;
        d_s = 8'h00;
      end
    end
    fr = 10'h2EE;
    for (int k = 1; k <= 40; k++) begin
      tick_s(fr[(k-1)/4], k == 40, $sformatf("full2 k%0d", k));
    end
    idle_after_s("full");

    // Async reset during data bit 4 of 0x81 with a byte buffered
    wait_idle_s();
    send_s(8'h81);
    fr = 10'h302;
    for (int k = 1; k <= 22; k++) begin
      tick_s(fr[(k-1)/4], 1'b0, $sformatf("rst k%0d", k));
      if (k == 1) begin
        v_s = 1'b1;
        d_s = 8'h42;
      end
      if (k == 2) begin
        v_s = 1'b0;
        d_s = 8'h00;
      end
    end
    chk("rst line low before reset", 32'(line_s), 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("rst async line", 32'(line_s), 32'd1);
    chk("rst async ready", 32'(rdy_s), 32'd1);
    chk("rst async busy", 32'(busy_s), 32'd0);
    chk("rst async pkt", 32'(pkt_s), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    begin
      int lows;
      lows = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (line_s !== 1'b1 || busy_s !== 1'b0) lows++;
      end
      chk("rst no frame after release", 32'(lows), 32'd0);
    end

    // tx_valid rising together with reset release
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    v_s  = 1'b1;
    d_s  = 8'hC3;
    @(negedge clk);
    v_s = 1'b0;
    d_s = 8'h00;
    chk("relval accepted", 32'(rdy_s), 32'd0);
    chk("relval line high", 32'(line_s), 32'd1);
    fr = 10'h386;
    for (int k = 1; k <= 40; k++) begin
      tick_s(fr[(k-1)/4], k == 40, $sformatf("relval k%0d", k));
    end
    idle_after_s("relval");

    // Default parameters, 0x55, 434 cycles per bit
    @(negedge clk);
    v_d = 1'b1;
    d_d = 8'h55;
    @(negedge clk);
    v_d = 1'b0;
    d_d = 8'h00;
    chk("dflt accepted", 32'(rdy_d), 32'd0);
    chk("dflt line high in accept cycle", 32'(line_d), 32'd1);
    fr = 10'h2AA;
    rx = '0;
    for (int k = 1; k <= 4340; k++) begin
      @(negedge clk);
      if (line_d !== fr[(k-1)/434]) chk($sformatf("dflt line k%0d", k), 32'(line_d), 32'(fr[(k-1)/434]));
      else n_checks++;
      if (pkt_d !== (k == 4340)) chk($sformatf("dflt pkt k%0d", k), 32'(pkt_d), 32'(k == 4340));
      else n_checks++;
      if ((k - 1) % 434 == 217) rx[(k-1)/434] = line_d;
    end
    chk("dflt recovered byte", 32'(rx[8:1]), 32'h55);
    chk("dflt start bit", 32'(rx[0]), 32'd0);
    chk("dflt stop bit", 32'(rx[9]), 32'd1);
    @(negedge clk);
    chk("dflt busy after", 32'(busy_d), 32'd0);
    chk("dflt line after", 32'(line_d), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
